led_array_ctrl: RTL and testbench

- Parametrised multi-channel LED driver; successor to the single-LED `top` blinker.
- Drives `NUM_LEDS` outputs; each channel is independently set to OFF, ON, BLINK (programmable half-period) or PWM dim (programmable duty).
- Channels are configured at run time through a valid/ready write port.
- Sits at board top level between the clock/reset pins and the LED pins.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_channel.sv | 74 +++++++
 rtl/led_array_ctrl.sv | 73 +++++++
 tb/tb_led_array_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the multi-channel LED driver.
// Config fields are sized for the widest build; channels slice what they use.
package led_pkg;

    localparam int CHAN_W    = 4;
    localparam int CNT_MAX_W = 32;
    localparam int PWM_MAX_W = 16;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    typedef struct packed {
        led_mode_t              mode;
        logic [CNT_MAX_W-1:0]   period;
        logic [PWM_MAX_W-1:0]   duty;
    } led_cfg_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period/duty registers, blink counter and phase,
// and the registered LED drive.
import led_pkg::*;

module led_channel #(
    parameter int CNT_W = 24,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  led_cfg_t         cfg,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led
);

    led_mode_t        mode_q;
    logic [CNT_W-1:0] period_q;
    logic [PWM_W-1:0] duty_q;
    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;

    logic [CNT_W-1:0] cnt_d;
    logic             phase_d;
    logic             led_d;

    // Upper config bits are zero padding for narrower builds.
    logic unused_cfg;
    assign unused_cfg = ^cfg;

    always_comb begin
        cnt_d   = '0;
        phase_d = phase_q;
        led_d   = 1'b0;
        unique case (mode_q)
            LED_OFF: led_d = 1'b0;
            LED_ON:  led_d = 1'b1;
            LED_BLINK: begin
                led_d = phase_q;
                if (cnt_q == period_q) begin
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LED_PWM: led_d = (pwm_cnt < duty_q);
            default: led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= LED_OFF;
            period_q <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led      <= 1'b0;
        end else begin
            led <= led_d;
            if (load) begin
                mode_q   <= cfg.mode;
                period_q <= cfg.period[CNT_W-1:0];
                duty_q   <= cfg.duty[PWM_W-1:0];
                cnt_q    <= '0;
                phase_q  <= 1'b1;
            end else begin
                cnt_q   <= cnt_d;
                phase_q <= phase_d;
            end
        end
    end

endmodule

// File: rtl/led_array_ctrl.sv
// Multi-channel LED driver: config handshake, channel decode,
// shared PWM frame counter and one led_channel per output.
import led_pkg::*;

module led_array_ctrl #(
    parameter int NUM_LEDS = 4,
    parameter int CNT_W    = 24,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic [NUM_LEDS-1:0] led
);

    logic                accept;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [NUM_LEDS-1:0] load;
    led_cfg_t            cfg;

    assign accept = cfg_valid && cfg_ready;

    // One dead cycle after each accept; out-of-range channels still handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ready <= 1'b1;
        end else begin
            cfg_ready <= !accept;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_comb begin
        cfg        = '0;
        cfg.mode   = led_mode_t'(cfg_mode);
        cfg.period = CNT_MAX_W'(cfg_period);
        cfg.duty   = PWM_MAX_W'(cfg_duty);
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            load[i] = accept && (cfg_chan == CHAN_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_channel #(
            .CNT_W (CNT_W),
            .PWM_W (PWM_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load    (load[g]),
            .cfg     (cfg),
            .pwm_cnt (pwm_cnt),
            .led     (led[g])
        );
    end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Directed bench for led_array_ctrl: reset, ON/OFF latency, blink,
// PWM duty, handshake corners and async reset.
import led_pkg::*;

module tb_led_array_ctrl;

    localparam int NUM_LEDS = 4;
    localparam int CNT_W    = 24;
    localparam int PWM_W    = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [3:0]          cfg_chan = '0;
    logic [1:0]          cfg_mode = '0;
    logic [CNT_W-1:0]    cfg_period = '0;
    logic [PWM_W-1:0]    cfg_duty = '0;
    logic [NUM_LEDS-1:0] led;

    int n_checks = 0;
    int n_fails  = 0;

    led_array_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .CNT_W    (CNT_W),
        .PWM_W    (PWM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .led        (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ch, input logic [1:0] m,
                         input logic [CNT_W-1:0] p,
                         input logic [PWM_W-1:0] d);
        cfg_chan   = ch;
        cfg_mode   = m;
        cfg_period = p;
        cfg_duty   = d;
        cfg_valid  = 1'b1;
    endtask

    // Call away from posedge; returns #1 after the accepting edge.
    task automatic wr(input logic [3:0] ch, input logic [1:0] m,
                      input logic [CNT_W-1:0] p,
                      input logic [PWM_W-1:0] d);
        int n;
        drive(ch, m, p, d);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) check("wr_ready_timeout", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_rdy", 32'(cfg_ready), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_led", 32'(led), 32'd0);
        check("idle_rdy", 32'(cfg_ready), 32'd1);

        wr(4'd1, LED_ON, '0, '0);
        check("on_rdy_lo", 32'(cfg_ready), 32'd0);
        check("on_lat1", 32'(led[1]), 32'd0);
        step();
        check("on_lat2", 32'(led[1]), 32'd1);
        check("on_rdy_hi", 32'(cfg_ready), 32'd1);

        @(negedge clk);
        wr(4'd1, LED_OFF, '0, '0);
        check("off_rdy_lo", 32'(cfg_ready), 32'd0);
        check("off_lat1", 32'(led[1]), 32'd1);
        step();
        check("off_lat2", 32'(led[1]), 32'd0);
        check("off_rdy_hi", 32'(cfg_ready), 32'd1);

        @(negedge clk);
        wr(4'd0, LED_BLINK, 24'd3, '0);
        for (int j = 0; j < 16; j++) begin
            step();
            check("blink_p3", 32'(led[0]), 32'((j % 8) < 4));
        end

        @(negedge clk);
        wr(4'd2, LED_BLINK, 24'd0, '0);
        for (int j = 0; j < 8; j++) begin
            step();
            check("blink_p0", 32'(led[2]), 32'((j % 2) == 0));
        end

        @(negedge clk);
        drive(4'd0, LED_OFF, '0, '0);
        step();
        check("b2b_rdy_lo1", 32'(cfg_ready), 32'd0);
        drive(4'd2, LED_ON, '0, '0);
        step();
        check("b2b_rdy_hi", 32'(cfg_ready), 32'd1);
        check("b2b_led0_off", 32'(led[0]), 32'd0);
        step();
        check("b2b_rdy_lo2", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        step();
        check("b2b_led", 32'(led), 32'h4);
        check("b2b_rdy_end", 32'(cfg_ready), 32'd1);

        @(negedge clk);
        wr(4'd9, LED_ON, '0, '0);
        check("ch9_rdy_lo", 32'(cfg_ready), 32'd0);
        for (int j = 0; j < 4; j++) begin
            step();
            check("ch9_led", 32'(led), 32'h4);
        end

        @(negedge clk);
        wr(4'd3, LED_PWM, '0, 8'd64);
        cnt = 0;
        repeat (256) begin
            step();
            cnt += int'(led[3]);
        end
        check("pwm_64", 32'(cnt), 32'd64);

        @(negedge clk);
        wr(4'd3, LED_PWM, '0, 8'd0);
        cnt = 0;
        repeat (256) begin
            step();
            cnt += int'(led[3]);
        end
        check("pwm_0", 32'(cnt), 32'd0);

        @(negedge clk);
        wr(4'd3, LED_PWM, '0, 8'd255);
        cnt = 0;
        repeat (256) begin
            step();
            cnt += int'(led[3]);
        end
        check("pwm_255", 32'(cnt), 32'd255);

        @(negedge clk);
        wr(4'd0, LED_BLINK, 24'd3, '0);
        step();
        step();
        check("pre_rst_led0", 32'(led[0]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_led", 32'(led), 32'd0);
        check("arst_rdy", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        wr(4'd1, LED_ON, '0, '0);
        check("first_edge_rdy", 32'(cfg_ready), 32'd0);
        for (int j = 0; j < 10; j++) begin
            step();
            check("post_rst_led", 32'(led), 32'h2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
